// File: rtl/truth_table_sweeper.sv
// Programmable N-input boolean function held as a minterm mask; sweeps all input combinations on request.
// Latency: first result one enabled cycle after start is accepted; last result and done at 2^N enabled cycles.
// Backpressure: step_en low pauses the sweep (valid drops, index/outputs hold); load/start ignored while sweeping.
module truth_table_sweeper #(
   parameter int                  N          = 3,
   parameter logic [(2**N)-1:0]   RESET_MASK = 8'h20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [(2**N)-1:0]    mask_in,
   input  logic                 start,
   input  logic                 step_en,
   output logic [N-1:0]         x_out,
   output logic                 s_out,
   output logic                 valid,
   output logic                 busy,
   output logic                 done,
   output logic [N:0]           ones_count,
   output logic [(2**N)-1:0]    mask
);

   localparam int             M        = 2**N;
   localparam logic [N-1:0]   IDX_ONE  = N'(1);
   localparam logic [N-1:0]   IDX_LAST = {N{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [M-1:0]    mask_q, mask_d;
   logic [N-1:0]    idx_q, idx_d;
   logic [N-1:0]    x_q, x_d;
   logic            s_q, s_d;
   logic            valid_q, valid_d;
   logic            done_q, done_d;
   logic [N:0]      cnt_q, cnt_d;

   // State and datapath registers; synchronous reset restores the power-on function and clears the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= RESET_MASK;
         idx_q   <= '0;
         x_q     <= '0;
         s_q     <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: mask writes and sweep launch only outside SWEEP; one minterm per enabled cycle in SWEEP.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      x_d     = x_q;
      s_d     = s_q;
      valid_d = 1'b0;
      done_d  = done_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (load) begin
               mask_d = mask_in;
            end
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         SWEEP: begin
            if (step_en) begin
               x_d     = idx_q;
               s_d     = mask_q[idx_q];
               valid_d = 1'b1;
               cnt_d   = cnt_q + (N+1)'(mask_q[idx_q]);
               idx_d   = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign x_out      = x_q;
   assign s_out      = s_q;
   assign valid      = valid_q;
   assign busy       = (state_q == SWEEP);
   assign done       = done_q;
   assign ones_count = cnt_q;
   assign mask       = mask_q;

endmodule
